in_cond: RTL and testbench

IN_COND -- requirements
Module: in_cond

---
 rtl/in_cond.sv | 77 +++++++
 tb/tb_in_cond.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/in_cond.sv
// in_cond: synchronizes three raw inputs, debounces each with a STABLE/PENDING
// run counter, pulses chg on any accepted change and counts rejected glitches.
module in_cond #(
  parameter int STABLE_CNT = 4,
  parameter int GLITCH_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          raw_in,
  input  logic                en,
  output logic                in,
  output logic                in2,
  output logic                in3,
  output logic                chg,
  output logic [GLITCH_W-1:0] glitch_cnt
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int SW = GLITCH_W + 2;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);
  localparam logic [SW-1:0] MAX = {2'b00, {GLITCH_W{1'b1}}};
  typedef enum logic {STABLE, PENDING} state_t;
  logic [2:0] sync1, sync2, lvl, lvl_nx, rej;
  state_t st [3];
  state_t st_nx [3];
  logic [CW-1:0] run [3];
  logic [CW-1:0] run_nx [3];
  logic [SW-1:0] sum;
  // en low leaves every channel in STABLE with a cleared run, so nothing resumes
  always_comb begin
    lvl_nx = lvl;
    rej = '0;
    for (int i = 0; i < 3; i++) begin
      st_nx[i] = STABLE;
      run_nx[i] = '0;
      if (en && sync2[i] != lvl[i]) begin
        if (st[i] == STABLE) begin
          st_nx[i] = PENDING;
          run_nx[i] = CW'(1);
        end else if (run[i] == LAST) begin
          lvl_nx[i] = ~lvl[i];
        end else begin
          st_nx[i] = PENDING;
          run_nx[i] = run[i] + 1'b1;
        end
      end else if (en) begin
        rej[i] = st[i] == PENDING;
      end
    end
    sum = {2'b00, glitch_cnt} + SW'(rej[0]) + SW'(rej[1]) + SW'(rej[2]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl <= '0;
      chg <= 1'b0;
      glitch_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        st[i] <= STABLE;
        run[i] <= '0;
      end
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      lvl <= lvl_nx;
      chg <= |(lvl ^ lvl_nx);
      glitch_cnt <= sum > MAX ? '1 : sum[GLITCH_W-1:0];
      for (int i = 0; i < 3; i++) begin
        st[i] <= st_nx[i];
        run[i] <= run_nx[i];
      end
    end
  end
  assign in = lvl[0];
  assign in2 = lvl[1];
  assign in3 = lvl[2];
endmodule

// File: tb/tb_in_cond.sv
// tb_in_cond: directed and random checks of in_cond against a streak-based reference model.
module tb_in_cond;
  localparam int SC = 4;
  logic clk = 0, rst = 1, en = 0;
  logic [2:0] raw_in = '0;
  logic in, in2, in3, chg, b_in, b_in2, b_in3, b_chg;
  logic [7:0] glitch_cnt;
  logic [1:0] b_gc;
  int tests = 0, fails = 0;
  logic [2:0] s1 = '0, s2 = '0, m_out = '0;
  logic m_chg = 0;
  int m_gl8 = 0, m_gl2 = 0, m_rej = 0;
  int streak [3] = '{0, 0, 0};
  wire [17:0] act = {in3, in2, in, chg, glitch_cnt, b_in3, b_in2, b_in, b_chg, b_gc};
  wire [17:0] mdl = {m_out, m_chg, m_gl8[7:0], m_out, m_chg, m_gl2[1:0]};

  always #5 clk = ~clk;

  in_cond #(.STABLE_CNT(SC)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .en(en),
    .in(in), .in2(in2), .in3(in3), .chg(chg), .glitch_cnt(glitch_cnt)
  );
  in_cond #(.STABLE_CNT(SC), .GLITCH_W(2)) dut2 (
    .clk(clk), .rst(rst), .raw_in(raw_in), .en(en),
    .in(b_in), .in2(b_in2), .in3(b_in3), .chg(b_chg), .glitch_cnt(b_gc)
  );

  // a level is accepted once the twice-delayed raw value has differed for SC enabled cycles
  always @(posedge clk) begin
    if (rst) begin
      s1 = '0; s2 = '0; m_out = '0; m_chg = 0; m_gl8 = 0; m_gl2 = 0;
      for (int i = 0; i < 3; i++) streak[i] = 0;
    end else begin
      m_rej = 0;
      m_chg = 0;
      for (int i = 0; i < 3; i++) begin
        if (!en) streak[i] = 0;
        else if (s2[i] != m_out[i]) begin
          streak[i]++;
          if (streak[i] == SC) begin
            m_out[i] = ~m_out[i];
            streak[i] = 0;
            m_chg = 1;
          end
        end else begin
          if (streak[i] > 0) m_rej++;
          streak[i] = 0;
        end
      end
      m_gl8 = (m_gl8 + m_rej > 255) ? 255 : m_gl8 + m_rej;
      m_gl2 = (m_gl2 + m_rej > 3) ? 3 : m_gl2 + m_rej;
      s2 = s1;
      s1 = raw_in;
    end
  end

  task automatic do_reset(input logic [2:0] r);
    @(negedge clk);
    rst = 1; raw_in = r; en = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; raw_in = 3'b111; en = 1;
    repeat (2) @(negedge clk);
    tests++;
    if (act !== 18'd0) begin fails++; $display("FAIL reset_state: dut=%h required=0", act); end
    rst = 0;
    for (int j = 1; j <= SC + 3; j++) begin
      @(negedge clk);
      tests++;
      if ({in3, in2, in} !== ((j >= SC + 2) ? 3'b111 : 3'b000))
        begin fails++; $display("FAIL release_edge%0d: dut=%b required=%b", j, {in3, in2, in}, (j >= SC + 2) ? 3'b111 : 3'b000); end
      tests++;
      if (act !== mdl) begin fails++; $display("FAIL release_model: dut=%h model=%h", act, mdl); end
    end
  endtask

  task automatic test_latency;
    do_reset(3'b000);
    repeat (4) @(negedge clk);
    raw_in = 3'b001;
    for (int j = 0; j < SC + 4; j++) begin
      @(negedge clk);
      tests++;
      if ({in, chg, glitch_cnt} !== {j >= SC + 1, j == SC + 1, 8'd0})
        begin fails++; $display("FAIL latency_edge%0d: in=%b chg=%b gc=%0d required in=%b chg=%b gc=0", j, in, chg, glitch_cnt, j >= SC + 1, j == SC + 1); end
      tests++;
      if (act !== mdl) begin fails++; $display("FAIL latency_model: dut=%h model=%h", act, mdl); end
    end
  endtask

  task automatic test_pulse(input logic [2:0] mask, input int len);
    logic [2:0] base, o0;
    int g0, pop, flips, chgs, maxd, prev, d, want;
    base = raw_in; o0 = m_out; g0 = m_gl8; pop = $countones(mask);
    flips = 0; chgs = 0; maxd = 0; prev = m_gl8;
    @(negedge clk);
    raw_in = base ^ mask;
    for (int j = 0; j < len + 2 * SC + 4; j++) begin
      @(negedge clk);
      tests++;
      if (act !== mdl) begin fails++; $display("FAIL pulse%0d_model: dut=%h model=%h", len, act, mdl); end
      if ({in3, in2, in} !== o0) flips++;
      if (chg) chgs++;
      d = int'(glitch_cnt) - prev;
      if (d > maxd) maxd = d;
      prev = int'(glitch_cnt);
      raw_in = (j < len - 1) ? base ^ mask : base;
    end
    want = (g0 + pop > 255) ? 255 : g0 + pop;
    tests++;
    if (len < SC) begin
      if (flips != 0 || chgs != 0 || glitch_cnt !== 8'(want) || maxd != pop)
        begin fails++; $display("FAIL short_pulse%0d: flips=%0d chg=%0d gc=%0d step=%0d required 0 0 %0d %0d", len, flips, chgs, glitch_cnt, maxd, want, pop); end
    end else begin
      if (flips == 0 || glitch_cnt !== 8'(g0))
        begin fails++; $display("FAIL long_pulse%0d: flips=%0d gc=%0d required flips>0 gc=%0d", len, flips, glitch_cnt, g0); end
    end
  endtask

  task automatic test_saturate;
    do_reset(3'b000);
    repeat (4) @(negedge clk);
    for (int n = 1; n <= 5; n++) begin
      test_pulse(3'b001, SC - 1);
      tests++;
      if (b_gc !== ((n > 3) ? 2'd3 : 2'(n))) begin fails++; $display("FAIL saturate%0d: gc2=%0d required=%0d", n, b_gc, (n > 3) ? 3 : n); end
    end
  endtask

  task automatic test_en;
    do_reset(3'b000);
    repeat (4) @(negedge clk);
    raw_in = 3'b100;
    for (int j = 0; j < 4; j++) @(negedge clk);
    en = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      tests++;
      if ({in3, chg, act !== mdl} !== 3'b000) begin fails++; $display("FAIL en_low%0d: in3=%b chg=%b dut=%h model=%h", j, in3, chg, act, mdl); end
    end
    en = 1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      tests++;
      if ({in3, glitch_cnt} !== {j >= SC - 1, 8'd0})
        begin fails++; $display("FAIL en_rise%0d: in3=%b gc=%0d required in3=%b gc=0", j, in3, glitch_cnt, j >= SC - 1); end
      tests++;
      if (act !== mdl) begin fails++; $display("FAIL en_model: dut=%h model=%h", act, mdl); end
    end
  endtask

  task automatic test_reset_mid;
    raw_in = 3'b011;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    tests++;
    if (act !== 18'd0) begin fails++; $display("FAIL reset_mid: dut=%h required=0", act); end
    rst = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      tests++;
      if (act !== mdl) begin fails++; $display("FAIL post_reset_model: dut=%h model=%h", act, mdl); end
    end
  endtask

  task automatic test_random;
    for (int j = 0; j < 3000; j++) begin
      @(negedge clk);
      tests++;
      if (act !== mdl) begin fails++; $display("FAIL random%0d: dut=%h model=%h", j, act, mdl); end
      for (int b = 0; b < 3; b++) if ($urandom_range(5) == 0) raw_in[b] = ~raw_in[b];
      en = en ? ($urandom_range(24) != 0) : ($urandom_range(2) == 0);
      rst = $urandom_range(299) == 0;
    end
    rst = 0;
  endtask

  initial begin
    test_reset;
    test_latency;
    test_pulse(3'b010, SC - 1);
    test_pulse(3'b010, SC);
    test_pulse(3'b111, SC - 1);
    test_saturate;
    test_en;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
